// File: rtl/cpu_params_pkg.sv
// CPU-wide widths and CSR address constants shared by the CSR commit pipe.
package cpu_params_pkg;

    localparam int unsigned RSZ     = 32;
    localparam int unsigned CSR_ASZ = 12;

    localparam logic [CSR_ASZ-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ASZ-1:0] CSR_MIE     = 12'h304;
    localparam logic [CSR_ASZ-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ASZ-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ASZ-1:0] CSR_MIP     = 12'h344;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Pipe-entry payload carried through the MEM (S1) and WB (S2) slots.
package cpu_structs_pkg;

    import cpu_params_pkg::*;

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic [CSR_ASZ-1:0] addr;
        logic [RSZ-1:0]     mdata;
        logic               ill;
        logic [CSR_ASZ-1:0] ill_addr;
    } csr_pipe_entry_t;

endpackage

// File: rtl/functions_pkg.sv
// Helper functions for CSR handling: WARL write masks per CSR address.
package functions_pkg;

    import cpu_params_pkg::*;

    // Writable-bit mask; unlisted CSRs are treated as fully writable.
    function automatic logic [RSZ-1:0] csr_wmask(input logic [CSR_ASZ-1:0] addr);
        case (addr)
            CSR_MSTATUS:      return RSZ'(32'h0000_1888);
            CSR_MIE, CSR_MIP: return RSZ'(32'h0000_0888);
            CSR_MTVEC:        return RSZ'(32'hFFFF_FFFD);
            CSR_MEPC:         return RSZ'(32'hFFFF_FFFC);
            default:          return '1;
        endcase
    endfunction

endpackage

// File: rtl/csr_commit_if.sv
// EXE request, lookup, CSR-file write and trap signals of the CSR commit pipe.
interface csr_commit_if;

    import cpu_params_pkg::*;

    logic               exe_valid_in;
    logic               exe_ready_out;
    logic               exe_csr_wr_in;
    logic [CSR_ASZ-1:0] exe_csr_addr_in;
    logic [RSZ-1:0]     exe_csr_wr_data_in;
    logic               exe_ill_in;
    logic [CSR_ASZ-1:0] exe_ill_addr_in;
    logic               flush_in;
    logic               wb_stall_in;
    logic [CSR_ASZ-1:0] lu_addr_in;
    logic               lu_hit_out;
    logic [RSZ-1:0]     lu_data_out;
    logic               lu_avail_out;
    logic               csr_we_out;
    logic [CSR_ASZ-1:0] csr_waddr_out;
    logic [RSZ-1:0]     csr_wdata_out;
    logic               ill_trap_out;
    logic [CSR_ASZ-1:0] ill_trap_addr_out;

    modport master (
        output exe_valid_in, exe_csr_wr_in, exe_csr_addr_in, exe_csr_wr_data_in,
               exe_ill_in, exe_ill_addr_in, flush_in, wb_stall_in, lu_addr_in,
        input  exe_ready_out, lu_hit_out, lu_data_out, lu_avail_out,
               csr_we_out, csr_waddr_out, csr_wdata_out, ill_trap_out, ill_trap_addr_out
    );

    modport slave (
        input  exe_valid_in, exe_csr_wr_in, exe_csr_addr_in, exe_csr_wr_data_in,
               exe_ill_in, exe_ill_addr_in, flush_in, wb_stall_in, lu_addr_in,
        output exe_ready_out, lu_hit_out, lu_data_out, lu_avail_out,
               csr_we_out, csr_waddr_out, csr_wdata_out, ill_trap_out, ill_trap_addr_out
    );

endinterface

// File: rtl/csr_fwd_match.sv
// Two-entry priority lookup of in-flight CSR writes; the younger slot (S1) wins.
module csr_fwd_match
    import cpu_params_pkg::*;
(
    input  logic               s1_fwd,
    input  logic [CSR_ASZ-1:0] s1_addr,
    input  logic [RSZ-1:0]     s1_data,
    input  logic               s2_fwd,
    input  logic [CSR_ASZ-1:0] s2_addr,
    input  logic [RSZ-1:0]     s2_data,
    input  logic [CSR_ASZ-1:0] lu_addr,
    output logic               hit,
    output logic [RSZ-1:0]     data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (s1_fwd && (s1_addr == lu_addr)) begin
            hit  = 1'b1;
            data = s1_data;
        end else if (s2_fwd && (s2_addr == lu_addr)) begin
            hit  = 1'b1;
            data = s2_data;
        end
    end

endmodule

// File: rtl/csr_commit.sv
// Two-slot in-order CSR write pipe (MEM/WB): WARL masking, commit, illegal-CSR trap, forwarding.
// Build option CSR_COMMIT_FWD_EN: forward in-flight values to EXE instead of stalling it.
module csr_commit
    import cpu_params_pkg::*;
    import functions_pkg::*;
    import cpu_structs_pkg::*;
(
    input  logic         clk_in,
    input  logic         reset_in,
    csr_commit_if.slave  bus
);

    csr_pipe_entry_t s1;
    csr_pipe_entry_t s2;
    csr_pipe_entry_t cap;
    logic            retire;
    logic            s2_free;
    logic            kill;
    logic            ready;
    logic            capture;
    logic            advance;
    logic            match_hit;
    logic [RSZ-1:0]  match_data;

    assign retire  = s2.valid & ~bus.wb_stall_in;
    assign s2_free = ~s2.valid | retire;
    assign kill    = retire & s2.ill;
    assign ready   = ~s1.valid | s2_free;
    assign capture = bus.exe_valid_in & ready & ~bus.flush_in & ~kill;
    // A flushed or killed S1 entry must not slip into WB.
    assign advance = s1.valid & s2_free & ~bus.flush_in & ~kill;

    always_comb begin
        cap          = '0;
        cap.valid    = 1'b1;
        cap.wr       = bus.exe_csr_wr_in;
        cap.addr     = bus.exe_csr_addr_in;
        cap.mdata    = bus.exe_csr_wr_data_in & csr_wmask(bus.exe_csr_addr_in);
        cap.ill      = bus.exe_ill_in;
        cap.ill_addr = bus.exe_ill_addr_in;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (advance)     s2       <= s1;
            else if (retire) s2.valid <= 1'b0;

            if (capture)                              s1       <= cap;
            else if (advance || bus.flush_in || kill) s1.valid <= 1'b0;
        end
    end

    assign bus.exe_ready_out     = ready;
    assign bus.csr_we_out        = retire & s2.wr & ~s2.ill;
    assign bus.csr_waddr_out     = s2.addr;
    assign bus.csr_wdata_out     = s2.mdata;
    assign bus.ill_trap_out      = kill;
    assign bus.ill_trap_addr_out = s2.ill_addr;

    csr_fwd_match u_fwd_match (
        .s1_fwd  (s1.valid & s1.wr & ~s1.ill),
        .s1_addr (s1.addr),
        .s1_data (s1.mdata),
        .s2_fwd  (s2.valid & s2.wr & ~s2.ill),
        .s2_addr (s2.addr),
        .s2_data (s2.mdata),
        .lu_addr (bus.lu_addr_in),
        .hit     (match_hit),
        .data    (match_data)
    );

    assign bus.lu_hit_out = match_hit;

`ifdef CSR_COMMIT_FWD_EN
    assign bus.lu_data_out  = match_data;
    assign bus.lu_avail_out = 1'b1;
`else
    // EXE waits for the commit, so the forwarded value is not exposed.
    logic unused_fwd_data;
    assign unused_fwd_data  = ^match_data;
    assign bus.lu_data_out  = '0;
    assign bus.lu_avail_out = ~match_hit;
`endif

endmodule

// File: tb/tb_csr_commit.sv
// Directed self-checking bench for csr_commit: commit latency, ordering, stall, trap, flush, reset.
module tb_csr_commit;

    import cpu_params_pkg::*;

`ifdef CSR_COMMIT_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    csr_commit_if bus ();

    csr_commit dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exe(input logic v, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic ill, input logic [11:0] ia);
        bus.exe_valid_in       = v;
        bus.exe_csr_wr_in      = wr;
        bus.exe_csr_addr_in    = a;
        bus.exe_csr_wr_data_in = d;
        bus.exe_ill_in         = ill;
        bus.exe_ill_addr_in    = ia;
    endtask

    task automatic idle();
        exe(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
    endtask

    // Next drive slot: negedge, then outputs settle 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [11:0] a, input logic [31:0] d);
        check({tag, ".we"}, 32'(bus.csr_we_out), 32'(we));
        if (we) begin
            check({tag, ".waddr"}, 32'(bus.csr_waddr_out), 32'(a));
            check({tag, ".wdata"}, bus.csr_wdata_out, d);
        end
    endtask

    task automatic chk_lu(input string tag, input logic hit, input logic [31:0] d);
        check({tag, ".hit"}, 32'(bus.lu_hit_out), 32'(hit));
        check({tag, ".data"}, bus.lu_data_out, FWD ? d : 32'h0);
        check({tag, ".avail"}, 32'(bus.lu_avail_out), FWD ? 32'd1 : 32'(!hit));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.flush_in    = 1'b0;
        bus.wb_stall_in = 1'b0;
        bus.lu_addr_in  = 12'h000;
        idle();
        #2;
        check("rst.ready", 32'(bus.exe_ready_out), 32'd1);
        check("rst.we", 32'(bus.csr_we_out), 32'd0);
        check("rst.trap", 32'(bus.ill_trap_out), 32'd0);
        chk_lu("rst.lu", 1'b0, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Single write to MEPC: low two bits masked, commit after two edges.
        exe(1'b1, 1'b1, 12'h341, 32'h8000_0003, 1'b0, 12'h000);
        bus.lu_addr_in = 12'h341;
        #1 check("t1.ready", 32'(bus.exe_ready_out), 32'd1);
        chk_lu("t1.c0", 1'b0, 32'h0);
        cyc(); idle();
        #1 chk_wr("t1.c1", 1'b0, 12'h0, 32'h0);
        chk_lu("t1.c1", 1'b1, 32'h8000_0000);
        cyc();
        #1 chk_wr("t1.c2", 1'b1, 12'h341, 32'h8000_0000);
        chk_lu("t1.c2", 1'b1, 32'h8000_0000);
        cyc();
        #1 chk_wr("t1.c3", 1'b0, 12'h0, 32'h0);
        chk_lu("t1.c3", 1'b0, 32'h0);

        // Back-to-back MTVEC writes: younger S1 value wins the lookup.
        cyc();
        exe(1'b1, 1'b1, 12'h305, 32'h0000_0100, 1'b0, 12'h000);
        bus.lu_addr_in = 12'h305;
        cyc();
        exe(1'b1, 1'b1, 12'h305, 32'h0000_0205, 1'b0, 12'h000);
        #1 chk_lu("t2.c1", 1'b1, 32'h0000_0100);
        cyc(); idle();
        #1 chk_lu("t2.c2", 1'b1, 32'h0000_0205);
        chk_wr("t2.c2", 1'b1, 12'h305, 32'h0000_0100);
        cyc();
        #1 chk_wr("t2.c3", 1'b1, 12'h305, 32'h0000_0205);
        chk_lu("t2.c3", 1'b1, 32'h0000_0205);
        cyc();
        #1 chk_wr("t2.c4", 1'b0, 12'h0, 32'h0);

        // WB stall with both slots full: EXE held off, then in-order drain.
        cyc();
        bus.wb_stall_in = 1'b1;
        exe(1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 12'h000);
        cyc();
        exe(1'b1, 1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0, 12'h000);
        #1 check("t3.ready_s2free", 32'(bus.exe_ready_out), 32'd1);
        cyc();
        exe(1'b1, 1'b1, 12'h341, 32'h0000_0004, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t3.stall%0d.ready", i), 32'(bus.exe_ready_out), 32'd0);
            chk_wr($sformatf("t3.stall%0d", i), 1'b0, 12'h0, 32'h0);
            cyc();
        end
        bus.wb_stall_in = 1'b0;
        #1 check("t3.rel.ready", 32'(bus.exe_ready_out), 32'd1);
        chk_wr("t3.rel0", 1'b1, 12'h300, 32'h0000_1888);
        cyc(); idle();
        #1 chk_wr("t3.rel1", 1'b1, 12'h304, 32'h0000_0888);
        cyc();
        #1 chk_wr("t3.rel2", 1'b1, 12'h341, 32'h0000_0004);
        cyc();
        #1 chk_wr("t3.rel3", 1'b0, 12'h0, 32'h0);

        // Illegal access traps and kills the younger MSTATUS write.
        cyc();
        exe(1'b1, 1'b0, 12'hC00, 32'h0, 1'b1, 12'hC00);
        bus.lu_addr_in = 12'h300;
        cyc();
        exe(1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 12'h000);
        cyc(); idle();
        #1 check("t4.trap", 32'(bus.ill_trap_out), 32'd1);
        check("t4.trap_addr", 32'(bus.ill_trap_addr_out), 32'h0000_0C00);
        chk_wr("t4.c2", 1'b0, 12'h0, 32'h0);
        chk_lu("t4.c2", 1'b1, 32'h0000_1888);
        cyc();
        #1 check("t4.trap_off", 32'(bus.ill_trap_out), 32'd0);
        chk_wr("t4.c3", 1'b0, 12'h0, 32'h0);
        chk_lu("t4.c3", 1'b0, 32'h0);
        cyc();
        #1 chk_wr("t4.c4", 1'b0, 12'h0, 32'h0);

        // Flush during MIE retire: MIE commits, the S1 MSTATUS write and EXE input die.
        cyc();
        exe(1'b1, 1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0, 12'h000);
        cyc();
        exe(1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 12'h000);
        cyc();
        exe(1'b1, 1'b1, 12'h341, 32'h0000_0008, 1'b0, 12'h000);
        bus.flush_in = 1'b1;
        #1 chk_wr("t5.c2", 1'b1, 12'h304, 32'h0000_0888);
        cyc(); idle();
        bus.flush_in = 1'b0;
        #1 chk_wr("t5.c3", 1'b0, 12'h0, 32'h0);
        chk_lu("t5.c3.300", 1'b0, 32'h0);
        bus.lu_addr_in = 12'h341;
        #1 chk_lu("t5.c3.341", 1'b0, 32'h0);
        cyc();
        #1 chk_wr("t5.c4", 1'b0, 12'h0, 32'h0);

        // Async reset in the middle of a full-pipe stall.
        cyc();
        bus.wb_stall_in = 1'b1;
        bus.lu_addr_in  = 12'h305;
        exe(1'b1, 1'b1, 12'h305, 32'h0000_0010, 1'b0, 12'h000);
        cyc();
        exe(1'b1, 1'b1, 12'h341, 32'h0000_0020, 1'b0, 12'h000);
        cyc(); idle();
        #1 check("t6.full.ready", 32'(bus.exe_ready_out), 32'd0);
        chk_lu("t6.full", 1'b1, 32'h0000_0010);
        #1 rst_n = 1'b0;
        #1 check("t6.rst.ready", 32'(bus.exe_ready_out), 32'd1);
        chk_lu("t6.rst", 1'b0, 32'h0);
        chk_wr("t6.rst", 1'b0, 12'h0, 32'h0);
        cyc();
        rst_n = 1'b1;
        bus.wb_stall_in = 1'b0;
        cyc();
        #1 check("t6.post.ready", 32'(bus.exe_ready_out), 32'd1);
        chk_lu("t6.post", 1'b0, 32'h0);
        chk_wr("t6.post", 1'b0, 12'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
